// File: rtl/adv7513_init_seq.sv
// ADV7513 power-up register sequencer: paces LUT-driven I2C writes,
// retries failed entries and restarts on hot-plug.
module adv7513_init_seq #(
    parameter int unsigned NUM_REGS   = 31,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned PWR_DELAY  = 10_000_000,
    parameter int unsigned RETRY_GAP  = 50_000,
    parameter int unsigned TIMEOUT    = 2_000_000,
    parameter logic [6:0]  SLAVE_ADDR = 7'h72
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       done,
    input  logic       fail,
    input  logic       HDMI_INT,
    output logic       start,
    output logic [6:0] slave_address,
    output logic [2:0] byte_num,
    output logic [7:0] byte_lut,
    output logic       busy,
    output logic       config_done,
    output logic       config_error,
    output logic [1:0] retry_count
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT_ACK,
        NEXT,
        RETRY_WAIT,
        CONFIGURED,
        ERROR
    } state_t;

    localparam logic [23:0] PWR_LAST  = 24'(PWR_DELAY - 1);
    localparam logic [23:0] GAP_LAST  = 24'(RETRY_GAP - 1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT - 1);
    localparam logic [7:0]  LUT_LAST  = 8'(NUM_REGS - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]  lut_q, lut_d;
    logic [1:0]  retry_q, retry_d;

    // {HDMI_INT, fail, done}: two sync stages plus a history stage
    logic [2:0] meta_q, sync_q, prev_q;
    logic [2:0] rise;
    logic       done_e, fail_e, hdmi_e;

    assign rise   = sync_q & ~prev_q;
    assign done_e = rise[0];
    assign fail_e = rise[1];
    assign hdmi_e = rise[2];

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            lut_q   <= '0;
            retry_q <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lut_q   <= lut_d;
            retry_q <= retry_d;
            meta_q  <= {HDMI_INT, fail, done};
            sync_q  <= meta_q;
            prev_q  <= sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        lut_d   = lut_q;
        retry_d = retry_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
        unique case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // a simultaneous done+fail is treated as a failure
                if (fail_e || cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 2'd1;
                        state_d = RETRY_WAIT;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (done_e) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                retry_d = '0;
                if (lut_q == LUT_LAST) begin
                    state_d = CONFIGURED;
                end else begin
                    lut_d   = lut_q + 8'd1;
                    state_d = ISSUE;
                end
            end
            RETRY_WAIT: begin
                if (cnt_q == GAP_LAST) state_d = ISSUE;
            end
            CONFIGURED, ERROR: begin
                if (hdmi_e) begin
                    lut_d   = '0;
                    retry_d = '0;
                    state_d = RETRY_WAIT;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
        // every state transition restarts the shared delay/timeout counter
        cnt_d = (state_d != state_q) ? '0 : cnt_inc;
    end

    always_comb begin
        start         = (state_q == ISSUE) || (state_q == WAIT_ACK);
        config_done   = (state_q == CONFIGURED);
        config_error  = (state_q == ERROR);
        busy          = !(config_done || config_error);
        byte_lut      = lut_q;
        retry_count   = retry_q;
        slave_address = SLAVE_ADDR;
        byte_num      = 3'd2;
    end

endmodule

// File: tb/tb_adv7513_init_seq.sv
// Directed bench for adv7513_init_seq with a scripted I2C master
// answering each start with a done or fail pulse.
module tb_adv7513_init_seq;

    localparam int unsigned NR = 4;
    localparam int unsigned PD = 20;
    localparam int unsigned RG = 10;
    localparam int unsigned TO = 100;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       done = 1'b0;
    logic       fail = 1'b0;
    logic       HDMI_INT = 1'b0;
    logic       start;
    logic [6:0] slave_address;
    logic [2:0] byte_num;
    logic [7:0] byte_lut;
    logic       busy;
    logic       config_done;
    logic       config_error;
    logic [1:0] retry_count;

    int checks = 0;
    int errors = 0;

    adv7513_init_seq #(
        .NUM_REGS  (NR),
        .MAX_RETRY (3),
        .PWR_DELAY (PD),
        .RETRY_GAP (RG),
        .TIMEOUT   (TO),
        .SLAVE_ADDR(7'h72)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .done         (done),
        .fail         (fail),
        .HDMI_INT     (HDMI_INT),
        .start        (start),
        .slave_address(slave_address),
        .byte_num     (byte_num),
        .byte_lut     (byte_lut),
        .busy         (busy),
        .config_done  (config_done),
        .config_error (config_error),
        .retry_count  (retry_count)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_start(input logic lvl, input int max, output int n);
        n = 0;
        while (start !== lvl && n < max) begin
            @(negedge clk_50);
            n++;
        end
    endtask

    // One transaction: wait for start, check entry, answer after 3 cycles
    task automatic serve(input string tag, input bit ok,
                         input logic [7:0] exp_lut, input logic [1:0] exp_rc);
        int n;
        wait_start(1'b1, 400, n);
        check({tag, " start"}, 32'(start), 32'd1);
        check({tag, " lut"}, 32'(byte_lut), 32'(exp_lut));
        check({tag, " rc"}, 32'(retry_count), 32'(exp_rc));
        repeat (3) @(negedge clk_50);
        if (ok) done = 1'b1;
        else fail = 1'b1;
        @(negedge clk_50);
        done = 1'b0;
        fail = 1'b0;
        wait_start(1'b0, 20, n);
        check({tag, " ack"}, 32'(start), 32'd0);
    endtask

    task automatic pulse_hdmi();
        HDMI_INT = 1'b1;
        @(negedge clk_50);
        HDMI_INT = 1'b0;
    endtask

    task automatic restart(input string tag);
        int n;
        reset = 1'b1;
        @(negedge clk_50);
        reset = 1'b0;
        wait_start(1'b1, 100, n);
        check({tag, " pwr delay"}, 32'(n), PD);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk_50);
        check("rst start", 32'(start), 32'd0);
        check("rst lut", 32'(byte_lut), 32'd0);
        check("rst rc", 32'(retry_count), 32'd0);
        check("rst done", 32'(config_done), 32'd0);
        check("rst err", 32'(config_error), 32'd0);
        check("rst busy", 32'(busy), 32'd1);
        check("slave addr", 32'(slave_address), 32'h72);
        check("byte num", 32'(byte_num), 32'd2);

        // clean pass
        reset = 1'b0;
        wait_start(1'b1, 100, n);
        check("t1 pwr delay", 32'(n), PD);
        for (int i = 0; i < 4; i++)
            serve($sformatf("t1 e%0d", i), 1'b1, 8'(i), 2'd0);
        repeat (3) @(negedge clk_50);
        check("t1 cfg done", 32'(config_done), 32'd1);
        check("t1 cfg err", 32'(config_error), 32'd0);
        check("t1 busy", 32'(busy), 32'd0);
        check("t1 lut", 32'(byte_lut), 32'd3);

        // hot-plug after configuration, then a mid-pass pulse is ignored
        pulse_hdmi();
        repeat (4) @(negedge clk_50);
        check("t5 cfg done", 32'(config_done), 32'd0);
        check("t5 busy", 32'(busy), 32'd1);
        check("t5 lut", 32'(byte_lut), 32'd0);
        serve("t5 e0", 1'b1, 8'd0, 2'd0);
        pulse_hdmi();
        for (int i = 1; i < 4; i++)
            serve($sformatf("t5 e%0d", i), 1'b1, 8'(i), 2'd0);
        repeat (3) @(negedge clk_50);
        check("t5 cfg done2", 32'(config_done), 32'd1);

        // entry 2 fails twice, then succeeds
        restart("t2");
        serve("t2 e0", 1'b1, 8'd0, 2'd0);
        serve("t2 e1", 1'b1, 8'd1, 2'd0);
        serve("t2 e2a", 1'b0, 8'd2, 2'd0);
        serve("t2 e2b", 1'b0, 8'd2, 2'd1);
        serve("t2 e2c", 1'b1, 8'd2, 2'd2);
        serve("t2 e3", 1'b1, 8'd3, 2'd0);
        repeat (3) @(negedge clk_50);
        check("t2 cfg done", 32'(config_done), 32'd1);
        check("t2 cfg err", 32'(config_error), 32'd0);
        check("t2 rc", 32'(retry_count), 32'd0);

        // entry 1 always fails: initial try plus three retries
        restart("t3");
        serve("t3 e0", 1'b1, 8'd0, 2'd0);
        for (int i = 0; i < 4; i++)
            serve($sformatf("t3 e1 try%0d", i), 1'b0, 8'd1, 2'(i));
        repeat (3) @(negedge clk_50);
        check("t3 cfg err", 32'(config_error), 32'd1);
        check("t3 cfg done", 32'(config_done), 32'd0);
        check("t3 busy", 32'(busy), 32'd0);
        check("t3 lut", 32'(byte_lut), 32'd1);
        check("t3 rc", 32'(retry_count), 32'd3);
        wait_start(1'b1, 50, n);
        check("t3 no start", 32'(n), 32'd50);
        pulse_hdmi();
        repeat (4) @(negedge clk_50);
        check("t3 err clr", 32'(config_error), 32'd0);
        check("t3 lut clr", 32'(byte_lut), 32'd0);
        check("t3 rc clr", 32'(retry_count), 32'd0);
        for (int i = 0; i < 4; i++)
            serve($sformatf("t3 rerun e%0d", i), 1'b1, 8'(i), 2'd0);
        repeat (3) @(negedge clk_50);
        check("t3 rerun done", 32'(config_done), 32'd1);

        // silent master: ISSUE cycle plus TO cycles in WAIT_ACK
        restart("t4");
        wait_start(1'b0, 200, n);
        check("t4 start len", 32'(n), TO + 1);
        check("t4 rc", 32'(retry_count), 32'd1);
        check("t4 busy", 32'(busy), 32'd1);
        wait_start(1'b1, 50, n);
        check("t4 retry gap", 32'(n), RG);
        serve("t4 e0 retry", 1'b1, 8'd0, 2'd1);
        serve("t4 e1", 1'b1, 8'd1, 2'd0);

        // reset while entry 2 waits for its ack
        wait_start(1'b1, 50, n);
        check("t6 lut", 32'(byte_lut), 32'd2);
        repeat (5) @(negedge clk_50);
        check("t6 in wait", 32'(start), 32'd1);
        reset = 1'b1;
        #1;
        check("t6 start abort", 32'(start), 32'd0);
        check("t6 lut abort", 32'(byte_lut), 32'd0);
        check("t6 busy", 32'(busy), 32'd1);
        @(negedge clk_50);
        reset = 1'b0;
        wait_start(1'b1, 100, n);
        check("t6 pwr delay", 32'(n), PD);
        check("t6 lut restart", 32'(byte_lut), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adv7513_init_seq.md
ADV7513_INIT_SEQ -- requirements
Module: adv7513_init_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 31: number of register-write transactions (LUT entries) per configuration pass.
REQ-002 SHALL have parameter MAX_RETRY, default 3: retries allowed per entry after a failed or timed-out transaction.
REQ-003 SHALL have parameter PWR_DELAY, default 10_000_000: clk_50 cycles to wait before the first transaction (200 ms).
REQ-004 SHALL have parameter RETRY_GAP, default 50_000: clk_50 cycles to wait between a failure and its retry.
REQ-005 SHALL have parameter TIMEOUT, default 2_000_000: clk_50 cycles to wait for done or fail before counting an attempt as failed.
REQ-006 SHALL have parameter SLAVE_ADDR, default 7'h72: I2C address of the main register map.
REQ-007 clk_50  in  1  the single 50 MHz clock; all state is clocked on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 done  in  1  transaction-complete level from the I2C master (slow clock domain).
REQ-010 fail  in  1  transaction-failed level from the I2C master (slow clock domain).
REQ-011 HDMI_INT  in  1  ADV7513 interrupt (hot-plug), asynchronous.
REQ-012 start  out  1  transaction request to the I2C master.
REQ-013 slave_address  out  7  always SLAVE_ADDR.
REQ-014 byte_num  out  3  always 3'd2 (register + data).
REQ-015 byte_lut  out  8  LUT index of the current entry.
REQ-016 busy  out  1  high while a configuration pass is in progress.
REQ-017 config_done  out  1  high once all NUM_REGS entries succeed; stays high until the next pass starts.
REQ-018 config_error  out  1  high once an entry exhausts its retries; stays high until the next pass starts.
REQ-019 retry_count  out  2  retries used on the current entry.

Function
REQ-020 done, fail and HDMI_INT SHALL each pass through a 2-flop synchronizer; only rising edges of the synchronized signals SHALL be acted on.
REQ-021 FSM states SHALL be: PWR_WAIT, ISSUE, WAIT_ACK, NEXT, RETRY_WAIT, CONFIGURED, ERROR.
REQ-022 PWR_WAIT SHALL count PWR_DELAY cycles, then go to ISSUE; busy=1 in every state except CONFIGURED and ERROR.
REQ-023 ISSUE SHALL drive start=1, clear the timeout counter, and go to WAIT_ACK on the next cycle.
REQ-024 In WAIT_ACK, start SHALL stay 1 until a done edge, a fail edge or the timeout; start SHALL deassert in the cycle the FSM leaves WAIT_ACK.
REQ-025 A done edge in WAIT_ACK SHALL go to NEXT; done and fail edges in the same cycle SHALL be treated as fail.
REQ-026 A fail edge in WAIT_ACK, or the timeout counter reaching TIMEOUT-1, SHALL go to RETRY_WAIT if retry_count<MAX_RETRY (incrementing retry_count), otherwise to ERROR.
REQ-027 RETRY_WAIT SHALL count RETRY_GAP cycles, then go to ISSUE with byte_lut unchanged.
REQ-028 NEXT SHALL clear retry_count; if byte_lut==NUM_REGS-1 it SHALL go to CONFIGURED, else increment byte_lut and go to ISSUE. byte_lut SHALL never wrap past NUM_REGS-1.
REQ-029 CONFIGURED SHALL set config_done=1; ERROR SHALL set config_error=1. Neither flag SHALL ever be high together with the other.
REQ-030 An HDMI_INT edge in CONFIGURED or ERROR SHALL clear byte_lut, retry_count, config_done and config_error, and go to RETRY_WAIT (short delay, then re-run from entry 0).
REQ-031 An HDMI_INT edge in any other state SHALL be ignored; the current pass continues.
REQ-032 Done or fail edges outside WAIT_ACK SHALL be ignored.
REQ-033 All delay and timeout counters SHALL be 24 bits and SHALL saturate rather than wrap.

Reset
REQ-034 On reset: state=PWR_WAIT; start=0, byte_lut=0, retry_count=0, config_done=0, config_error=0, busy=1; all counters and synchronizers cleared.
REQ-035 Reset asserted mid-transaction SHALL abort immediately; the pass SHALL restart from PWR_WAIT with no start pulse until PWR_DELAY has elapsed again.

Verification (PWR_DELAY=20, RETRY_GAP=10, TIMEOUT=100, NUM_REGS=4)
REQ-036 Test 1: release reset; answer every start with done -> four transactions, byte_lut 0,1,2,3; config_done=1, busy=0.
REQ-037 Test 2: entry 2 fails twice, then succeeds -> retry_count reaches 2; byte_lut holds 2 through both retries; config_done=1.
REQ-038 Test 3: entry 1 always fails -> 1 initial attempt plus 3 retries, then config_error=1 with byte_lut=1.
REQ-039 Test 4: no done or fail after start -> start deasserts 100 cycles after ISSUE and a retry follows.
REQ-040 Test 5: HDMI_INT pulse in CONFIGURED -> config_done=0 and a full 4-entry pass re-runs; an HDMI_INT pulse mid-pass has no effect.
REQ-041 Test 6: reset in WAIT_ACK of entry 2 -> start=0 and byte_lut=0 immediately; the next start appears after 20 cycles.
